// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-counter sizing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_rx_state_t;

    // Width of a counter that spans one bit period of DIVISOR clk cycles.
    function automatic int unsigned uart_cnt_width(input int unsigned divisor);
        return (divisor > 1) ? $clog2(divisor) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
    parameter int unsigned          WIDTH     = 1,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture; both stages come out of reset at RESET_VAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Asynchronous serial receiver (8N1 by default, LSB first).
// Start bit is validated at mid-bit; data and stop bits are sampled at their
// centres. A good frame gives a one-cycle o_dv, a low stop bit a one-cycle
// o_frame_err, after which the line must return high before the next frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DIVISOR = 100
) (
    input  logic             clk,
    input  logic             i_reset_n,
    input  logic             i_rx,
    output logic [WIDTH-1:0] o_data,
    output logic             o_dv,
    output logic             o_frame_err,
    output logic             o_busy
);

    localparam int unsigned    CW        = uart_cnt_width(DIVISOR);
    localparam int unsigned    IW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  HALF_LAST = CW'(DIVISOR / 2 - 1);
    localparam logic [CW-1:0]  FULL_LAST = CW'(DIVISOR - 1);
    localparam logic [IW-1:0]  IDX_LAST  = IW'(WIDTH - 1);

    logic                 rx_s;
    uart_rx_state_t       state;
    uart_rx_state_t       state_nx;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        bit_idx;
    logic [WIDTH-1:0]     shreg;
    logic                 half_tick;
    logic                 full_tick;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (i_reset_n),
        .d     (i_rx),
        .q     (rx_s)
    );

    assign half_tick = (cnt == HALF_LAST);
    assign full_tick = (cnt == FULL_LAST);

    // Next-state decode for the frame FSM.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (!rx_s)     state_nx = START;
            START:     if (half_tick) state_nx = rx_s ? IDLE : DATA;
            DATA:      if (full_tick && (bit_idx == IDX_LAST)) state_nx = STOP;
            STOP:      if (full_tick) state_nx = rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s)      state_nx = IDLE;
            default:                  state_nx = IDLE;
        endcase
    end

    // State register; o_busy is registered alongside so it tracks the state.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state  <= IDLE;
            o_busy <= 1'b0;
        end else begin
            state  <= state_nx;
            o_busy <= (state_nx == START) || (state_nx == DATA) || (state_nx == STOP);
        end
    end

    // Bit-period counter: cleared on any state change and after each full bit.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt <= '0;
        end else if (state_nx != state) begin
            cnt <= '0;
        end else if ((state == DATA || state == STOP) && full_tick) begin
            cnt <= '0;
        end else if (state == START || state == DATA || state == STOP) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Data path: shift in bits at centre, publish the word or flag a framing error.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            shreg       <= '0;
            bit_idx     <= '0;
            o_data      <= '0;
            o_dv        <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_dv        <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                START: bit_idx <= '0;
                DATA: begin
                    if (full_tick) begin
                        // Concatenate-then-shift keeps this legal for WIDTH == 1.
                        shreg   <= WIDTH'({rx_s, shreg} >> 1);
                        bit_idx <= (bit_idx == IDX_LAST) ? '0 : bit_idx + IW'(1);
                    end
                end
                STOP: begin
                    if (full_tick) begin
                        if (rx_s) begin
                            o_data <= shreg;
                            o_dv   <= 1'b1;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: DIVISOR=16 receiver plus a DIVISOR=104 receiver
// for the slow-baud case. Frames are driven by a bit-level transmitter model.
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_a;
    logic        rx_b;
    logic [7:0]  data_a;
    logic        dv_a;
    logic        fe_a;
    logic        busy_a;
    logic [7:0]  data_b;
    logic        dv_b;
    logic        fe_b;
    logic        busy_b;

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;

    // Pulse logs gathered by the monitor.
    int unsigned dv_n = 0;
    int unsigned dv_cyc [0:15];
    logic [31:0] dv_dat [0:15];
    int unsigned fe_n = 0;
    int unsigned fe_cyc = 0;
    int unsigned both_n = 0;
    int unsigned rise_cyc = 0;
    int unsigned fall_cyc = 0;
    logic        busy_prev = 1'b0;
    int unsigned dvb_n = 0;
    int unsigned dvb_cyc = 0;
    logic [31:0] dvb_dat = '0;
    int unsigned feb_n = 0;

    uart_rx #(.WIDTH(8), .DIVISOR(16)) dut (
        .clk         (clk),
        .i_reset_n   (rst_n),
        .i_rx        (rx_a),
        .o_data      (data_a),
        .o_dv        (dv_a),
        .o_frame_err (fe_a),
        .o_busy      (busy_a)
    );

    uart_rx #(.WIDTH(8), .DIVISOR(104)) dut_b (
        .clk         (clk),
        .i_reset_n   (rst_n),
        .i_rx        (rx_b),
        .o_data      (data_b),
        .o_dv        (dv_b),
        .o_frame_err (fe_b),
        .o_busy      (busy_b)
    );

    always #5 clk = ~clk;

    // Cycle counter: value after posedge N is N.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (dv_a) begin
            if (dv_n < 16) begin
                dv_cyc[dv_n] = cyc;
                dv_dat[dv_n] = 32'(data_a);
            end
            dv_n++;
        end
        if (fe_a) begin
            fe_cyc = cyc;
            fe_n++;
        end
        if ((dv_a && fe_a) || (dv_b && fe_b)) both_n++;
        if (busy_a && !busy_prev) rise_cyc = cyc;
        if (!busy_a && busy_prev) fall_cyc = cyc;
        busy_prev = busy_a;
        if (dv_b) begin
            dvb_cyc = cyc;
            dvb_dat = 32'(data_b);
            dvb_n++;
        end
        if (fe_b) feb_n++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input bit to_b, input logic v);
        if (to_b) rx_b = v;
        else      rx_a = v;
    endtask

    // Drive one frame, one clk per step, starting at posedge+1. t0 is the cycle
    // count when the start bit is driven; the DUT's E0 is the next posedge.
    // abort_at != 0 stops the frame at that cycle and returns the line to idle.
    task automatic send(input logic [7:0] data, input int unsigned dtx, input logic stop,
                        input bit to_b, input int unsigned abort_at, output int unsigned t0);
        logic [9:0] frame;
        frame = {stop, data, 1'b0};
        t0 = cyc;
        for (int unsigned c = 0; c < 10 * dtx; c++) begin
            if (abort_at != 0 && c == abort_at) begin
                set_line(to_b, 1'b1);
                return;
            end
            set_line(to_b, frame[c / dtx]);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int unsigned t0;
        int unsigned t1;
        int unsigned n0;
        int unsigned f0;

        rst_n = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(data_a), 32'h0);
        check("rst_dv", 32'(dv_a), 32'h0);
        check("rst_fe", 32'(fe_a), 32'h0);
        check("rst_busy", 32'(busy_a), 32'h0);
        check("rst_data_b", 32'(data_b), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_busy", 32'(busy_a), 32'h0);

        // Clean frame 0xA5: o_dv at E0+154, busy rises at E0+2.
        n0 = dv_n;
        f0 = fe_n;
        send(8'hA5, 16, 1'b1, 1'b0, 0, t0);
        repeat (10) @(posedge clk);
        #1;
        check("a5_dv_count", dv_n, n0 + 1);
        check("a5_data", dv_dat[n0], 32'hA5);
        check("a5_dv_cycle", dv_cyc[n0], t0 + 155);
        check("a5_busy_rise", rise_cyc, t0 + 3);
        check("a5_busy_fall", fall_cyc, t0 + 155);
        check("a5_no_fe", fe_n, f0);
        check("a5_hold", 32'(data_a), 32'hA5);

        // Back-to-back frames with one stop bit: strobes 160 cycles apart.
        n0 = dv_n;
        send(8'h00, 16, 1'b1, 1'b0, 0, t1);
        send(8'hFF, 16, 1'b1, 1'b0, 0, t0);
        send(8'h3C, 16, 1'b1, 1'b0, 0, t0);
        repeat (10) @(posedge clk);
        #1;
        check("b2b_dv_count", dv_n, n0 + 3);
        check("b2b_data0", dv_dat[n0], 32'h00);
        check("b2b_data1", dv_dat[n0 + 1], 32'hFF);
        check("b2b_data2", dv_dat[n0 + 2], 32'h3C);
        check("b2b_cycle0", dv_cyc[n0], t1 + 155);
        check("b2b_gap1", dv_cyc[n0 + 1] - dv_cyc[n0], 160);
        check("b2b_gap2", dv_cyc[n0 + 2] - dv_cyc[n0 + 1], 160);
        check("b2b_no_fe", fe_n, f0);

        // Five-cycle low glitch: START for 8 cycles then back to IDLE.
        n0 = dv_n;
        f0 = fe_n;
        rx_a = 1'b0;
        t0 = cyc;
        repeat (5) @(posedge clk);
        #1;
        rx_a = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("glitch_busy_rise", rise_cyc, t0 + 3);
        check("glitch_busy_fall", fall_cyc, t0 + 11);
        check("glitch_no_dv", dv_n, n0);
        check("glitch_no_fe", fe_n, f0);
        check("glitch_data", 32'(data_a), 32'h3C);

        // 0x55 with a low stop bit, then a 500-cycle break: one framing error.
        n0 = dv_n;
        f0 = fe_n;
        send(8'h55, 16, 1'b0, 1'b0, 0, t0);
        repeat (500) @(posedge clk);
        #1;
        rx_a = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("brk_fe_count", fe_n, f0 + 1);
        check("brk_fe_cycle", fe_cyc, t0 + 155);
        check("brk_no_dv", dv_n, n0);
        check("brk_data_kept", 32'(data_a), 32'h3C);
        send(8'h81, 16, 1'b1, 1'b0, 0, t0);
        repeat (10) @(posedge clk);
        #1;
        check("post_brk_dv", dv_n, n0 + 1);
        check("post_brk_data", 32'(data_a), 32'h81);
        check("post_brk_fe", fe_n, f0 + 1);

        // Reset during bit 4 of 0x12; the link partner abandons the frame too.
        n0 = dv_n;
        f0 = fe_n;
        send(8'h12, 16, 1'b1, 1'b0, 84, t0);
        check("mid_busy_before", 32'(busy_a), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", 32'(data_a), 32'h0);
        check("mid_rst_busy", 32'(busy_a), 32'h0);
        check("mid_rst_dv", 32'(dv_a), 32'h0);
        check("mid_rst_fe", 32'(fe_a), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("mid_no_dv", dv_n, n0);
        check("mid_no_fe", fe_n, f0);
        send(8'h34, 16, 1'b1, 1'b0, 0, t0);
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_dv", dv_n, n0 + 1);
        check("post_rst_data", 32'(data_a), 32'h34);

        // Transmitter at 17 cycles/bit: stop sample lands in bit 7 (0) -> error.
        n0 = dv_n;
        f0 = fe_n;
        send(8'h55, 17, 1'b1, 1'b0, 0, t0);
        repeat (40) @(posedge clk);
        #1;
        check("skew17_fe", fe_n, f0 + 1);
        check("skew17_fe_cycle", fe_cyc, t0 + 155);
        check("skew17_no_dv", dv_n, n0);
        check("skew17_data_kept", 32'(data_a), 32'h34);

        // Transmitter at 100 cycles/bit into the 104-cycle receiver.
        send(8'hC3, 100, 1'b1, 1'b1, 0, t0);
        repeat (20) @(posedge clk);
        #1;
        check("skew104_dv", dvb_n, 1);
        check("skew104_data", dvb_dat, 32'hC3);
        check("skew104_cycle", dvb_cyc, t0 + 991);
        check("skew104_no_fe", feb_n, 0);

        check("dv_fe_overlap", both_n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
